// File: rtl/hwpe_ctrl_package.sv
// Shared HWPE controller types: uloop control/flag bundles and the
// uloop sequencer state and command types.
package hwpe_ctrl_package;

  localparam int unsigned ULOOP_MAX_NB_REG   = 4;
  localparam int unsigned ULOOP_MAX_NB_LOOPS = 6;
  localparam int unsigned ULOOP_CNT_WIDTH    = 16;
  localparam int unsigned ULOOP_REG_WIDTH    = 32;
  localparam int unsigned ULOOP_ADDR_WIDTH   = 32;
  localparam int unsigned ULOOP_LOOP_WIDTH   = $clog2(ULOOP_MAX_NB_LOOPS);

  typedef struct packed {
    logic enable;
    logic clear;
  } ctrl_uloop_t;

  typedef struct packed {
    logic                                              valid;
    logic                                              ready;
    logic                                              done;
    logic [ULOOP_LOOP_WIDTH-1:0]                       loop;
    logic [ULOOP_MAX_NB_REG-1:0][ULOOP_REG_WIDTH-1:0]  offs;
    logic [ULOOP_MAX_NB_LOOPS-1:0][ULOOP_CNT_WIDTH-1:0] idx;
  } flags_uloop_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    REQ    = 3'd2,
    WAIT   = 3'd3,
    ISSUE  = 3'd4,
    FINISH = 3'd5
  } uloop_seq_state_e;

  typedef struct packed {
    logic [ULOOP_MAX_NB_REG-1:0][ULOOP_ADDR_WIDTH-1:0]  addr;
    logic [ULOOP_MAX_NB_LOOPS-1:0][ULOOP_CNT_WIDTH-1:0] idx;
    logic [ULOOP_LOOP_WIDTH-1:0]                        loop;
    logic                                               last;
  } uloop_cmd_t;

endpackage

// File: rtl/hwpe_ctrl_uloop_sequencer.sv
// Drives the uloop engine one iteration at a time and turns each flags
// response into a registered per-lane address command for the streamers.
module hwpe_ctrl_uloop_sequencer
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned NB_REG     = 4,
  parameter int unsigned NB_LOOPS   = 6,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             test_mode_i,
  input  logic                             clear_i,
  input  logic                             start_i,
  input  logic [NB_REG*ADDR_WIDTH-1:0]     base_addr_i,
  output ctrl_uloop_t                      uloop_ctrl_o,
  input  flags_uloop_t                     uloop_flags_i,
  output logic                             cmd_valid_o,
  input  logic                             cmd_ready_i,
  output logic [NB_REG*ADDR_WIDTH-1:0]     cmd_addr_o,
  output logic [NB_LOOPS*CNT_WIDTH-1:0]    cmd_idx_o,
  output logic [$clog2(NB_LOOPS)-1:0]      cmd_loop_o,
  output logic                             cmd_last_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [31:0]                      nb_iter_o
);

  localparam int unsigned LOOP_W = $clog2(NB_LOOPS);

  // Command handshake: a command transfers in a cycle where cmd_valid_o and
  // cmd_ready_i are both high; once raised, cmd_valid_o and the payload hold
  // until that transfer (or a clear) happens.

  uloop_seq_state_e state_q, state_d;

  logic [NB_REG-1:0][ADDR_WIDTH-1:0] base_q, base_d;
  logic [NB_REG-1:0][ADDR_WIDTH-1:0] lane_sum;
  uloop_cmd_t                        cmd_q, cmd_d;
  logic [31:0]                       nb_iter_q, nb_iter_d;

  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;

  // Per-lane adders: offsets are resized to the address width before the add.
  for (genvar g = 0; g < NB_REG; g++) begin : gen_lane
    assign lane_sum[g] = base_q[g] + ADDR_WIDTH'(uloop_flags_i.offs[g]);
    assign cmd_addr_o[g*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(cmd_q.addr[g]);
  end

  for (genvar g = 0; g < NB_LOOPS; g++) begin : gen_idx
    assign cmd_idx_o[g*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(cmd_q.idx[g]);
  end

  assign cmd_loop_o = LOOP_W'(cmd_q.loop);
  assign nb_iter_o  = nb_iter_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = INIT;
      INIT:    state_d = REQ;
      REQ:     if (uloop_flags_i.ready) state_d = WAIT;
      WAIT:    if (uloop_flags_i.valid) state_d = ISSUE;
      ISSUE:   if (cmd_ready_i) state_d = cmd_q.last ? FINISH : REQ;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_comb begin
    uloop_ctrl_o        = '0;
    uloop_ctrl_o.enable = (state_q == REQ) && uloop_flags_i.ready && !clear_i;
    uloop_ctrl_o.clear  = (state_q == INIT) || clear_i;
    cmd_valid_o         = (state_q == ISSUE);
    cmd_last_o          = (state_q == ISSUE) && cmd_q.last;
    busy_o              = (state_q != IDLE);
    done_o              = (state_q == FINISH) && !clear_i;
  end

  always_comb begin
    base_d    = base_q;
    cmd_d     = cmd_q;
    nb_iter_d = nb_iter_q;
    if (clear_i) begin
      base_d    = '0;
      cmd_d     = '0;
      nb_iter_d = '0;
    end else begin
      if (state_q == IDLE && start_i) begin
        base_d    = base_addr_i;
        nb_iter_d = '0;
      end
      if (state_q == WAIT && uloop_flags_i.valid) begin
        for (int i = 0; i < NB_REG; i++) begin
          cmd_d.addr[i] = ULOOP_ADDR_WIDTH'(lane_sum[i]);
        end
        for (int j = 0; j < NB_LOOPS; j++) begin
          cmd_d.idx[j] = uloop_flags_i.idx[j];
        end
        cmd_d.loop = uloop_flags_i.loop;
        cmd_d.last = uloop_flags_i.done;
      end
      if (state_q == ISSUE && cmd_ready_i) begin
        nb_iter_d = nb_iter_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q    <= '0;
      cmd_q     <= '0;
      nb_iter_q <= '0;
    end else begin
      base_q    <= base_d;
      cmd_q     <= cmd_d;
      nb_iter_q <= nb_iter_d;
    end
  end

endmodule

// File: doc/hwpe_ctrl_uloop_sequencer.md
Name: hwpe_ctrl_uloop_sequencer

Overview:
Initiator-side companion of the uloop microcode engine. It drives the uloop control interface (enable/clear), collects each flags response (offsets, indices, loop, done) and turns it into one address command per iteration toward the streamers, using a valid/ready handshake. It sits in the HWPE controller between the FSM start/stop logic and the streamer address ports.

Parameters:
NB_REG, 4, number of uloop offset registers and command address lanes
NB_LOOPS, 6, number of uloop nesting levels reported in flags
CNT_WIDTH, 16, width of each loop index
REG_WIDTH, 32, width of each uloop offset
ADDR_WIDTH, 32, width of each command address lane

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
test_mode_i  in  1  test mode (unused functionally)
clear_i  in  1  synchronous soft clear
start_i  in  1  single-cycle pulse that starts a sequence
base_addr_i  in  NB_REG*ADDR_WIDTH  per-lane base address, sampled on accepted start
uloop_ctrl_o  out  ctrl_uloop_t  {enable, clear} toward uloop
uloop_flags_i  in  flags_uloop_t  {valid, ready, done, loop, offs[], idx[]} from uloop
cmd_valid_o  out  1  command valid
cmd_ready_i  in  1  command accepted by streamers
cmd_addr_o  out  NB_REG*ADDR_WIDTH  base + offset per lane
cmd_idx_o  out  NB_LOOPS*CNT_WIDTH  loop indices of this iteration
cmd_loop_o  out  $clog2(NB_LOOPS)  innermost loop executed
cmd_last_o  out  1  final command of the sequence
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse at sequence end
nb_iter_o  out  32  commands handshaked since last accepted start

Behaviour:
- Reset and clear values: all outputs 0, state IDLE, holding register 0, nb_iter_o 0.
- FSM states: IDLE, INIT, REQ, WAIT, ISSUE, FINISH.
- IDLE: start_i -> sample base_addr_i, zero nb_iter_o, go INIT. start_i outside IDLE is ignored.
- INIT: uloop_ctrl_o.clear=1 for exactly one cycle, then REQ.
- REQ: wait for uloop_flags_i.ready=1; in that cycle assert uloop_ctrl_o.enable=1 (single cycle), go WAIT. enable is never asserted outside REQ.
- WAIT: on uloop_flags_i.valid capture offs, idx, loop and done into the holding register, go ISSUE. valid arriving in the same cycle as enable is not legal, because the response arrives at least 1 cycle after enable.
- ISSUE: cmd_valid_o=1 with payload driven from the holding register, stable until cmd_ready_i. On handshake, nb_iter_o+1 (wraps mod 2^32). Then go FINISH if captured done=1, else REQ.
- cmd_last_o = captured done, valid only while cmd_valid_o.
- FINISH: done_o=1 for one cycle, then IDLE.
- busy_o=1 in every state except IDLE.
- Address arithmetic:
  - cmd_addr_o[i] = base[i] + offs[i], modulo 2^ADDR_WIDTH.
  - offs is zero-extended if REG_WIDTH<ADDR_WIDTH and truncated if REG_WIDTH>ADDR_WIDTH.
  - Registered: payload changes only on capture.
- Command latency: minimum 1 cycle from flags.valid to cmd_valid_o. Minimum iteration period is 3 cycles (REQ, WAIT, ISSUE) with ready high.
- Clear:
  - clear_i in any state -> IDLE next cycle.
  - uloop_ctrl_o.clear is asserted combinationally in the same cycle.
  - cmd_valid_o drops next cycle, no done_o pulse, nb_iter_o cleared.
  - clear_i together with start_i: clear wins, start dropped.
- Reset mid-operation: immediate return to reset values, no handshake completion implied.
- No uloop response: WAIT stalls indefinitely and busy_o stays 1. Timeout is not provided; clear_i is the recovery path.

Decomposition:
- hwpe_ctrl_package gains:
  - uloop_seq_state_e: IDLE, INIT, REQ, WAIT, ISSUE, FINISH.
  - uloop_cmd_t: {addr[NB_REG], idx[NB_LOOPS], loop, last}, using the ULOOP_MAX_* constants for array bounds.
- ctrl_uloop_t and flags_uloop_t are reused unchanged.
- No sub-module; the per-lane adder array is a generate loop inside the block.

Test Plan:
- Basic sequence: base[0]=0x1000; model returns offs[0]=0,4,8 with done on the 3rd -> cmd_addr_o[0]=0x1000,0x1004,0x1008; cmd_last_o only on the 3rd; done_o one cycle after the 3rd handshake; nb_iter_o=3; exactly 3 enable pulses plus 1 clear pulse.
- Backpressure: cmd_ready_i low for 5 cycles during ISSUE -> cmd_valid_o and payload constant across all 5 cycles; uloop_ctrl_o.enable stays 0 until the handshake.
- Ready stall: flags.ready held 0 for 4 cycles in REQ -> no enable pulse; enable asserted in the first cycle ready=1.
- Wrap: ADDR_WIDTH=32, base=0xFFFF_FFFC, offs=8 -> cmd_addr_o=0x0000_0004.
- Clear mid-ISSUE: clear_i=1 -> uloop_ctrl_o.clear=1 the same cycle; next cycle cmd_valid_o=0, busy_o=0, nb_iter_o=0; no done_o pulse.
- Start handling: start_i while busy -> ignored, base unchanged; start_i together with clear_i -> stays IDLE.
